// File: rtl/l1d_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : l1d_mem_responder
// Description : Memory-side responder for the L1D D_* interface. Serves
//               4-beat line-fill reads and single-beat lane-masked writes
//               from a local word array.
// Revision    : 1.0 - initial release
// ============================================================================
module l1d_mem_responder #(
    parameter int DEPTH_WORDS = 16384,
    parameter int LAT         = 1,
    parameter int GAP         = 0,
    parameter int BURST_LEN   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        D_req,
    input  logic [31:0] D_addr,
    input  logic        D_write,
    input  logic [31:0] D_in,
    input  logic [2:0]  D_type,
    output logic [31:0] D_out,
    output logic        D_wait,
    output logic        busy
);
    localparam int         c_IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_LAT        = 4'(LAT);
    localparam logic [3:0] c_GAP        = 4'(GAP);
    localparam logic [1:0] c_LAST_BEAT  = 2'(BURST_LEN - 1);
    localparam logic [2:0] c_TYPE_BYTE    = 3'b000;
    localparam logic [2:0] c_TYPE_HWORD   = 3'b001;
    localparam logic [2:0] c_TYPE_BYTE_U  = 3'b100;
    localparam logic [2:0] c_TYPE_HWORD_U = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LWAIT = 3'd1,
        S_RBEAT = 3'd2,
        S_RGAP  = 3'd3,
        S_WBEAT = 3'd4
    } state_t;

    logic [31:0] mem [0:DEPTH_WORDS-1];

    state_t               state_q,   state_d;
    logic [3:0]           lat_cnt_q, lat_cnt_d;
    logic [3:0]           gap_cnt_q, gap_cnt_d;
    logic [1:0]           beat_q,    beat_d;
    logic [c_IDX_W-1:0]   base_q,    base_d;
    logic                 wr_q,      wr_d;
    logic [31:0]          din_q,     din_d;
    logic [2:0]           type_q,    type_d;
    logic [1:0]           lane_q,    lane_d;
    logic [31:0]          dout_q,    dout_d;
    logic                 dwait_q,   dwait_d;
    logic                 busy_q,    busy_d;

    logic [c_IDX_W-1:0]   w_rd_idx;
    logic [3:0]           w_wr_mask;
    logic                 unused_addr_hi;

    assign unused_addr_hi = ^D_addr[31:c_IDX_W+2];

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        gap_cnt_d = gap_cnt_q;
        beat_d    = beat_q;
        base_d    = base_q;
        wr_d      = wr_q;
        din_d     = din_q;
        type_d    = type_q;
        lane_d    = lane_q;

        case (state_q)
            S_IDLE: begin
                if (D_req) begin
                    wr_d   = D_write;
                    din_d  = D_in;
                    type_d = D_type;
                    lane_d = D_addr[1:0];
                    beat_d = 2'd0;
                    // Reads fetch the whole aligned line; writes target one word.
                    base_d = D_write ? D_addr[c_IDX_W+1:2]
                                     : {D_addr[c_IDX_W+1:4], 2'b00};
                    if (LAT == 0) begin
                        state_d = D_write ? S_WBEAT : S_RBEAT;
                    end else begin
                        state_d   = S_LWAIT;
                        lat_cnt_d = c_LAT;
                    end
                end
            end
            S_LWAIT: begin
                lat_cnt_d = lat_cnt_q - 4'd1;
                if (lat_cnt_q == 4'd1) begin
                    state_d = wr_q ? S_WBEAT : S_RBEAT;
                end
            end
            S_RBEAT: begin
                beat_d = beat_q + 2'd1;
                if (beat_q == c_LAST_BEAT) begin
                    state_d = S_IDLE;
                end else if (GAP == 0) begin
                    state_d = S_RBEAT;
                end else begin
                    state_d   = S_RGAP;
                    gap_cnt_d = c_GAP;
                end
            end
            S_RGAP: begin
                gap_cnt_d = gap_cnt_q - 4'd1;
                if (gap_cnt_q == 4'd1) begin
                    state_d = S_RBEAT;
                end
            end
            S_WBEAT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the next state.
        w_rd_idx = base_d + c_IDX_W'(beat_d);
        dwait_d  = !((state_d == S_RBEAT) || (state_d == S_WBEAT));
        dout_d   = (state_d == S_RBEAT) ? mem[w_rd_idx] : 32'd0;
        busy_d   = (state_d != S_IDLE);
    end

    always_comb begin
        w_wr_mask = 4'b1111;
        case (type_q)
            c_TYPE_BYTE, c_TYPE_BYTE_U:   w_wr_mask = 4'b0001 << lane_q;
            c_TYPE_HWORD, c_TYPE_HWORD_U: w_wr_mask = lane_q[1] ? 4'b1100 : 4'b0011;
            default:                      w_wr_mask = 4'b1111;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            lat_cnt_q <= 4'd0;
            gap_cnt_q <= 4'd0;
            beat_q    <= 2'd0;
            base_q    <= '0;
            wr_q      <= 1'b0;
            din_q     <= 32'd0;
            type_q    <= 3'd0;
            lane_q    <= 2'd0;
            dout_q    <= 32'd0;
            dwait_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            beat_q    <= beat_d;
            base_q    <= base_d;
            wr_q      <= wr_d;
            din_q     <= din_d;
            type_q    <= type_d;
            lane_q    <= lane_d;
            dout_q    <= dout_d;
            dwait_q   <= dwait_d;
            busy_q    <= busy_d;
        end
    end

    // Array is never reset; the write lands on the edge closing WBEAT.
    always_ff @(posedge clk) begin
        if (rst && (state_q == S_WBEAT)) begin
            for (int k = 0; k < 4; k++) begin
                if (w_wr_mask[k]) begin
                    mem[base_q][8*k +: 8] <= din_q[8*k +: 8];
                end
            end
        end
    end

    assign D_out  = dout_q;
    assign D_wait = dwait_q;
    assign busy   = busy_q;

endmodule
`default_nettype wire
